// File: rtl/cache_fill_fsm_if.sv
// Miss / fill signal bundle between the cache, memory and fill FSM.
// master drives miss and return data; slave is the fill FSM.
interface cache_fill_fsm_if #(
    parameter int ADDR_W = 16,
    parameter int WORDS  = 8
);
    localparam int IDX_W = $clog2(WORDS);

    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              memory_data_valid;
    logic              fsm_busy;
    logic              mem_read_en;
    logic [ADDR_W-1:0] memory_address;
    logic              write_data_array;
    logic [IDX_W-1:0]  word_index;
    logic              write_tag_array;

    modport master (
        output miss_detected,
        output miss_address,
        output memory_data_valid,
        input  fsm_busy,
        input  mem_read_en,
        input  memory_address,
        input  write_data_array,
        input  word_index,
        input  write_tag_array
    );

    modport slave (
        input  miss_detected,
        input  miss_address,
        input  memory_data_valid,
        output fsm_busy,
        output mem_read_en,
        output memory_address,
        output write_data_array,
        output word_index,
        output write_tag_array
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache block fill FSM: issues WORDS back-to-back reads from the
// aligned block base and writes returning words until the last one.
module cache_fill_fsm #(
    parameter int ADDR_W     = 16,
    parameter int WORDS      = 8,
    parameter int WORD_BYTES = 2
) (
    input logic             clk,
    input logic             rst_n,
    cache_fill_fsm_if.slave bus
);
    localparam int IDX_W   = $clog2(WORDS);
    localparam int CNT_W   = IDX_W + 1;
    localparam int OFF_W   = $clog2(WORDS * WORD_BYTES);
    localparam int BYTE_SH = $clog2(WORD_BYTES);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base, base_nx;
    logic [CNT_W-1:0]  issue_cnt, issue_nx;
    logic [IDX_W-1:0]  recv_cnt, recv_nx;

    logic rd_en;
    logic wr_en;
    logic last;

    // Outputs decoded from registered state plus the returning-data strobe
    always_comb begin
        rd_en = (state == FILL) && (issue_cnt < CNT_MAX);
        wr_en = (state == FILL) && bus.memory_data_valid;
        last  = wr_en && (recv_cnt == LAST_IDX);

        bus.fsm_busy         = (state == FILL);
        bus.mem_read_en      = rd_en;
        bus.memory_address   = '0;
        bus.write_data_array = wr_en;
        bus.word_index       = '0;
        bus.write_tag_array  = last;

        if (rd_en) begin
            bus.memory_address = base + (ADDR_W'(issue_cnt) << BYTE_SH);
        end
        if (wr_en) begin
            bus.word_index = recv_cnt;
        end
    end

    // Next state: miss starts a fill, last returned word ends it
    always_comb begin
        state_nx = state;
        base_nx  = base;
        issue_nx = issue_cnt;
        recv_nx  = recv_cnt;

        unique case (state)
            IDLE: begin
                if (bus.miss_detected) begin
                    state_nx = FILL;
                    base_nx  = {bus.miss_address[ADDR_W-1:OFF_W],
                                {OFF_W{1'b0}}};
                    issue_nx = '0;
                    recv_nx  = '0;
                end
            end
            FILL: begin
                if (rd_en) begin
                    issue_nx = issue_cnt + 1'b1;
                end
                if (wr_en) begin
                    recv_nx = recv_cnt + 1'b1;
                end
                if (last) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    // State and counter registers; reset aborts any fill in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            state     <= state_nx;
            base      <= base_nx;
            issue_cnt <= issue_nx;
            recv_cnt  <= recv_nx;
        end
    end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: per-cycle model comparison plus
// directed scenarios with hand-computed literal expectations.
module tb_cache_fill_fsm;
    localparam int ADDR_W     = 16;
    localparam int WORDS      = 8;
    localparam int WORD_BYTES = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cache_fill_fsm_if #(.ADDR_W(ADDR_W), .WORDS(WORDS)) bus ();

    cache_fill_fsm #(
        .ADDR_W    (ADDR_W),
        .WORDS     (WORDS),
        .WORD_BYTES(WORD_BYTES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Model: a fill is a record (base, first cycle, words received).
    // Reads occur in the WORDS cycles after the fill starts; the k-th
    // valid pulse writes slot k; the WORDS-th pulse also writes the tag.
    int          cyc_n  = 0;
    bit          m_busy = 0;
    logic [15:0] m_base = '0;
    int          m_start = 0;
    int          m_recv  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0;
            m_base = '0;
            m_recv = 0;
        end else begin
            cyc_n++;
            if (!m_busy) begin
                if (bus.miss_detected) begin
                    m_busy  = 1;
                    m_base  = bus.miss_address & 16'hFFF0;
                    m_start = cyc_n;
                    m_recv  = 0;
                end
            end else if (bus.memory_data_valid) begin
                if (m_recv == WORDS - 1) m_busy = 0;
                else m_recv++;
            end
        end
    end

    int n_wr  = 0;
    int n_tag = 0;

    // Compare every DUT output against the model once per cycle
    always @(negedge clk) begin
        int          off;
        bit          e_rd, e_wr, e_tag;
        logic [15:0] e_addr;
        logic [2:0]  e_idx;
        off    = cyc_n - m_start;
        e_rd   = m_busy && off < WORDS;
        e_addr = e_rd ? 16'(m_base + off * WORD_BYTES) : 16'h0;
        e_wr   = m_busy && bus.memory_data_valid;
        e_idx  = e_wr ? 3'(m_recv) : 3'd0;
        e_tag  = e_wr && m_recv == WORDS - 1;
        chk("model_busy", 32'(bus.fsm_busy), 32'(m_busy));
        chk("model_rd", 32'(bus.mem_read_en), 32'(e_rd));
        chk("model_addr", 32'(bus.memory_address), 32'(e_addr));
        chk("model_wr", 32'(bus.write_data_array), 32'(e_wr));
        chk("model_idx", 32'(bus.word_index), 32'(e_idx));
        chk("model_tag", 32'(bus.write_tag_array), 32'(e_tag));
        if (bus.write_data_array) n_wr++;
        if (bus.write_tag_array) n_tag++;
    end

    logic        s_busy, s_rd, s_wr, s_tag;
    logic [15:0] s_addr;
    logic [2:0]  s_idx;

    // Drive one cycle, sample outputs mid-cycle, return after the edge
    task automatic cyc(input logic miss, input logic [15:0] addr,
                       input logic valid);
        bus.miss_detected     = miss;
        bus.miss_address      = addr;
        bus.memory_data_valid = valid;
        @(negedge clk);
        s_busy = bus.fsm_busy;
        s_rd   = bus.mem_read_en;
        s_addr = bus.memory_address;
        s_wr   = bus.write_data_array;
        s_idx  = bus.word_index;
        s_tag  = bus.write_tag_array;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, 32'(bus.fsm_busy), 0);
        chk({nm, "_rd"}, 32'(bus.mem_read_en), 0);
        chk({nm, "_addr"}, 32'(bus.memory_address), 0);
        chk({nm, "_wr"}, 32'(bus.write_data_array), 0);
        chk({nm, "_idx"}, 32'(bus.word_index), 0);
        chk({nm, "_tag"}, 32'(bus.write_tag_array), 0);
    endtask

    initial begin
        logic [31:0] vm;
        bus.miss_detected     = 1'b0;
        bus.miss_address      = '0;
        bus.memory_data_valid = 1'b0;
        #1;
        chk_all_zero("reset");
        cyc(1'b1, 16'h1234, 1'b1);
        cyc(1'b0, 16'h0, 1'b0);
        rst_n = 1'b1;

        // Stray valid while idle
        n_wr = 0;
        for (int c = 0; c < 3; c++) begin
            cyc(1'b0, 16'h0, 1'b1);
            chk("stray_wr", 32'(s_wr), 0);
            chk("stray_busy", 32'(s_busy), 0);
        end
        chk("stray_nwr", n_wr, 0);

        // Latency-4 fill
        n_wr = 0;
        n_tag = 0;
        for (int c = 0; c < 14; c++) begin
            cyc(c == 0, 16'h1236, c >= 5 && c <= 12);
            if (c == 0) chk("l4_busy0", 32'(s_busy), 0);
            if (c == 1) chk("l4_busy1", 32'(s_busy), 1);
            if (c == 1) chk("l4_addr1", 32'(s_addr), 32'h1230);
            if (c == 4) chk("l4_addr4", 32'(s_addr), 32'h1236);
            if (c == 8) chk("l4_addr8", 32'(s_addr), 32'h123E);
            if (c == 9) chk("l4_rd9", 32'(s_rd), 0);
            if (c == 5) chk("l4_idx5", 32'(s_idx), 0);
            if (c == 11) chk("l4_tag11", 32'(s_tag), 0);
            if (c == 12) chk("l4_tag12", 32'(s_tag), 1);
            if (c == 12) chk("l4_idx12", 32'(s_idx), 7);
            if (c == 13) chk("l4_busy13", 32'(s_busy), 0);
        end
        chk("l4_nwr", n_wr, 8);
        chk("l4_ntag", n_tag, 1);

        // Irregular valid pulses
        vm = (32'd1 << 3) | (32'd1 << 4) | (32'd1 << 7) | (32'd1 << 9) |
             (32'd1 << 10) | (32'd1 << 11) | (32'd1 << 14) | (32'd1 << 15);
        n_wr = 0;
        n_tag = 0;
        for (int c = 0; c < 17; c++) begin
            cyc(c == 0, 16'h0400, vm[c]);
            if (c == 7) chk("irr_idx7", 32'(s_idx), 2);
            if (c == 14) chk("irr_tag14", 32'(s_tag), 0);
            if (c == 15) chk("irr_tag15", 32'(s_tag), 1);
            if (c == 15) chk("irr_idx15", 32'(s_idx), 7);
            if (c == 16) chk("irr_busy16", 32'(s_busy), 0);
        end
        chk("irr_nwr", n_wr, 8);
        chk("irr_ntag", n_tag, 1);

        // Wrap-around at the top of the address space
        for (int c = 0; c < 11; c++) begin
            cyc(c == 0, 16'hFFF5, c >= 2 && c <= 9);
            if (c == 1) chk("wrap_addr1", 32'(s_addr), 32'hFFF0);
            if (c == 8) chk("wrap_addr8", 32'(s_addr), 32'hFFFE);
            if (c == 10) chk("wrap_busy10", 32'(s_busy), 0);
        end

        // Back-to-back misses with miss_detected held high
        n_tag = 0;
        for (int c = 0; c < 21; c++) begin
            cyc(c <= 11, c == 0 ? 16'h0040 : 16'h2000,
                (c >= 2 && c <= 9) || (c >= 12 && c <= 19));
            if (c == 5) chk("b2b_addr5", 32'(s_addr), 32'h0048);
            if (c == 9) chk("b2b_tag9", 32'(s_tag), 1);
            if (c == 10) chk("b2b_busy10", 32'(s_busy), 0);
            if (c == 11) chk("b2b_busy11", 32'(s_busy), 1);
            if (c == 11) chk("b2b_addr11", 32'(s_addr), 32'h2000);
            if (c == 18) chk("b2b_addr18", 32'(s_addr), 32'h200E);
            if (c == 20) chk("b2b_busy20", 32'(s_busy), 0);
        end
        chk("b2b_ntag", n_tag, 2);

        // Reset in the middle of a fill
        n_wr = 0;
        n_tag = 0;
        for (int c = 0; c < 5; c++) begin
            cyc(c == 0, 16'h0800, c >= 2 && c <= 4);
        end
        chk("rst_nwr", n_wr, 3);
        chk("rst_busy_pre", 32'(bus.fsm_busy), 1);
        bus.memory_data_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        cyc(1'b0, 16'h0, 1'b1);
        cyc(1'b0, 16'h0, 1'b0);
        rst_n = 1'b1;
        chk("rst_ntag", n_tag, 0);
        for (int c = 0; c < 11; c++) begin
            cyc(c == 0, 16'h0100, c >= 2 && c <= 9);
            if (c == 1) chk("rst_addr1", 32'(s_addr), 32'h0100);
            if (c == 9) chk("rst_tag9", 32'(s_tag), 1);
            if (c == 10) chk("rst_busy10", 32'(s_busy), 0);
        end
        chk("rst_nwr2", n_wr, 11);
        chk("rst_ntag2", n_tag, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the width of byte addresses.
REQ-002 Parameter WORDS, default 8, SHALL set the number of words per cache block; it SHALL be a power of two and at least 2.
REQ-003 Parameter WORD_BYTES, default 2, SHALL set the bytes per word; it SHALL be a power of two.
REQ-004 clk  input  1  SHALL be the system clock, with all state updated on its rising edge.
REQ-005 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 miss_detected  input  1  SHALL be asserted high by the cache to request a block fill.
REQ-007 miss_address  input  ADDR_W  SHALL carry the byte address that missed; it is sampled only with miss_detected in IDLE.
REQ-008 memory_data_valid  input  1  SHALL mark the cycle in which the memory returns one word.
REQ-009 fsm_busy  output  1  SHALL be high while a fill is in progress, for use as the pipeline stall signal.
REQ-010 mem_read_en  output  1  SHALL request one memory read per cycle while high.
REQ-011 memory_address  output  ADDR_W  SHALL carry the byte address of the read being issued.
REQ-012 write_data_array  output  1  SHALL be the data-array write enable for the returning word.
REQ-013 word_index  output  clog2(WORDS)  SHALL select the word slot written by write_data_array.
REQ-014 write_tag_array  output  1  SHALL be the tag-array write enable, pulsed once per completed fill.

Function
REQ-015 The FSM SHALL have two states: IDLE and FILL.
REQ-016 In IDLE with miss_detected=1 at a rising edge, the block SHALL:
  - move to FILL;
  - latch base = miss_address with its low clog2(WORDS*WORD_BYTES) bits cleared;
  - clear issue_cnt and recv_cnt.
REQ-017 In FILL, miss_detected SHALL be ignored.
REQ-018 fsm_busy SHALL equal (state==FILL) and SHALL be driven from registered state only.
REQ-019 mem_read_en SHALL be 1 exactly when state==FILL and issue_cnt<WORDS; otherwise it SHALL be 0.
REQ-020 When mem_read_en=1, memory_address SHALL be base + issue_cnt*WORD_BYTES, computed modulo 2^ADDR_W; otherwise it SHALL be 0.
REQ-021 issue_cnt SHALL increment on each rising edge at which mem_read_en=1 and SHALL saturate at WORDS.
REQ-022 Reads SHALL therefore be issued back-to-back, WORDS consecutive cycles, starting in the first FILL cycle.
REQ-023 In FILL with memory_data_valid=1, write_data_array SHALL be 1 combinationally and word_index SHALL equal recv_cnt.
REQ-024 recv_cnt SHALL increment on each such edge.
REQ-025 The block SHALL work for any memory latency ≥1 cycle, including gaps between valid pulses, because completion SHALL be determined by recv_cnt alone.
REQ-026 When memory_data_valid=1 and recv_cnt==WORDS-1 in FILL, write_tag_array SHALL be 1 in that same cycle, and state SHALL return to IDLE at the next edge.
REQ-027 Outside those conditions, write_data_array and word_index SHALL be 0.
REQ-028 Outside the last-word condition, write_tag_array SHALL be 0.
REQ-029 memory_data_valid in IDLE SHALL cause no writes and no state change.
REQ-030 A miss_detected held high through completion SHALL start a new fill from the IDLE cycle that follows, re-sampling miss_address.
REQ-031 The minimum gap between two consecutive fills SHALL be one IDLE cycle.

Reset
REQ-032 Asserting rst_n=0 at any time, including mid-FILL, SHALL immediately force:
  - state=IDLE;
  - base, issue_cnt, recv_cnt = 0;
  - all outputs = 0.
REQ-033 After rst_n is released, the block SHALL accept a new miss at the first rising edge.
REQ-034 Words already written before the reset SHALL NOT be rolled back, and no tag write SHALL occur for the aborted fill.

Verification
REQ-035 The bench SHALL cover these directed scenarios, all at default parameters:
  - Latency-4 fill: miss_detected=1 with miss_address=0x1236 in cycle 0 -> fsm_busy=1 from cycle 1; memory_address 0x1230,0x1232,...,0x123E in cycles 1-8; with valid in cycles 5-12, word_index 0-7; write_tag_array=1 in cycle 12 only; fsm_busy=0 in cycle 13.
  - Irregular valid: valid pulses with gaps (e.g. cycles 3,4,7,9,10,11,14,15) -> exactly 8 data writes, indices in order, tag write coincident with the 8th pulse.
  - Wrap-around: miss_address=0xFFF5 -> base 0xFFF0; addresses 0xFFF0-0xFFFE, with no carry beyond ADDR_W bits.
  - Back-to-back misses: miss_detected held high, first 0x0040, then 0x2000 -> the second fill starts after one IDLE cycle; miss_detected asserted mid-FILL is ignored.
  - Mid-fill reset: rst_n=0 after 3 data writes -> all outputs 0 asynchronously; no write_tag_array; a new miss at 0x0100 after release completes normally.
  - Stray valid: memory_data_valid=1 while IDLE -> no write_data_array, no state change.
